// File: rtl/lfsr_scan_pkg.sv
// Shared widths, state encoding and seed-width helper for the LFSR seed scanner.
// Optional histogram build: LFSR_SCAN_HIST_EN.
package lfsr_scan_pkg;

    localparam int DEF_WIDTH  = 4;
    localparam int DEF_WIDTH2 = 3;
    localparam int DEF_LANES  = 5;

    function automatic int seed_width(input int w, input int w2);
        return 3 * w + 2 * w2;
    endfunction

    localparam int DEF_SEED_W = seed_width(DEF_WIDTH, DEF_WIDTH2);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        COUNT,
        EVAL,
        NEXT
    } scan_state_t;

endpackage

// File: rtl/lfsr_seed_scanner_if.sv
// Scanner control/status bundle; slave = scanner side, master = sequencer/sig_gen side.
// Optional histogram read port when LFSR_SCAN_HIST_EN is defined.
interface lfsr_seed_scanner_if
    import lfsr_scan_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int WIDTH2 = DEF_WIDTH2,
    parameter int LANES  = DEF_LANES
);
    localparam int SEED_W = seed_width(WIDTH, WIDTH2);

    logic              start;
    logic              busy;
    logic              done;
    logic              sg_reset;
    logic              sg_enable;
    logic [WIDTH-1:0]  INIT_0;
    logic [WIDTH-1:0]  INIT_1;
    logic [WIDTH-1:0]  INIT_2;
    logic [WIDTH2-1:0] INIT_3;
    logic [WIDTH2-1:0] INIT_4;
    logic [LANES-1:0]  pattern;
    logic              hit;
    logic [LANES:0]    cur_count;
    logic [LANES:0]    best_count;
    logic [SEED_W-1:0] best_seed;
`ifdef LFSR_SCAN_HIST_EN
    logic [LANES-1:0]  hist_addr;
    logic [LANES:0]    hist_data;

    modport slave (
        input  start, pattern, hist_addr,
        output busy, done, sg_reset, sg_enable,
        output INIT_0, INIT_1, INIT_2, INIT_3, INIT_4,
        output hit, cur_count, best_count, best_seed, hist_data
    );
    modport master (
        output start, pattern, hist_addr,
        input  busy, done, sg_reset, sg_enable,
        input  INIT_0, INIT_1, INIT_2, INIT_3, INIT_4,
        input  hit, cur_count, best_count, best_seed, hist_data
    );
`else
    modport slave (
        input  start, pattern,
        output busy, done, sg_reset, sg_enable,
        output INIT_0, INIT_1, INIT_2, INIT_3, INIT_4,
        output hit, cur_count, best_count, best_seed
    );
    modport master (
        output start, pattern,
        input  busy, done, sg_reset, sg_enable,
        input  INIT_0, INIT_1, INIT_2, INIT_3, INIT_4,
        input  hit, cur_count, best_count, best_seed
    );
`endif

endinterface

// File: rtl/lfsr_seed_scanner_pattern_tracker.sv
// Occurrence bitmap + popcount of observed patterns; optional histogram (LFSR_SCAN_HIST_EN).
// Latency: bitmap updates on the sampling edge, popcount and histogram read are combinational.
// Backpressure: none; samples every cycle that sample is high.
module pattern_tracker
    import lfsr_scan_pkg::*;
#(
    parameter int LANES = DEF_LANES
)(
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             sample,
    input  logic [LANES-1:0] pattern,
`ifdef LFSR_SCAN_HIST_EN
    input  logic [LANES-1:0] hist_addr,
    output logic [LANES:0]   hist_data,
`endif
    output logic [LANES:0]   uniq_count
);
    localparam int DEPTH = 1 << LANES;
    localparam int CW    = LANES + 1;

    logic [DEPTH-1:0] bitmap;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bitmap <= '0;
        end else if (clear) begin
            bitmap <= '0;
        end else if (sample) begin
            bitmap[pattern] <= 1'b1;
        end
    end

    // CW bits hold 2^LANES exactly, so the sum cannot wrap.
    always_comb begin
        uniq_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            uniq_count = uniq_count + CW'(bitmap[i]);
        end
    end

`ifdef LFSR_SCAN_HIST_EN
    logic [CW-1:0] hist [DEPTH];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
        end else if (sample && (hist[pattern] != '1)) begin
            hist[pattern] <= hist[pattern] + CW'(1);
        end
    end

    assign hist_data = hist[hist_addr];
`endif

endmodule

// File: rtl/lfsr_seed_scanner.sv
// Sweeps every sig_gen seed, counts unique lout patterns per seed, tracks the best seed.
// Latency: RUN_CYCLES+4 cycles per seed; histogram port present with LFSR_SCAN_HIST_EN.
// Backpressure: none; start is ignored while busy.
module lfsr_seed_scanner
    import lfsr_scan_pkg::*;
#(
    parameter int     WIDTH      = DEF_WIDTH,
    parameter int     WIDTH2     = DEF_WIDTH2,
    parameter int     LANES      = DEF_LANES,
    parameter int     RUN_CYCLES = 500,
    parameter int     THRESHOLD  = 24,
    parameter longint SEED_LAST  = (longint'(1) << (3 * WIDTH + 2 * WIDTH2)) - 1
)(
    input logic                clock,
    input logic                reset,
    lfsr_seed_scanner_if.slave bus
);
    localparam int                SEED_W   = seed_width(WIDTH, WIDTH2);
    localparam int                CW       = LANES + 1;
    localparam int                RC_W     = $clog2(RUN_CYCLES + 1);
    localparam logic [SEED_W-1:0] SEED_END = SEED_W'(SEED_LAST);
    localparam logic [RC_W-1:0]   RUN_END  = RC_W'(RUN_CYCLES - 1);
    localparam logic [31:0]       THR_U    = THRESHOLD;

    scan_state_t       state;
    logic [SEED_W-1:0] seed;
    logic [RC_W-1:0]   run_cnt;
    logic [CW-1:0]     cur_count;
    logic [CW-1:0]     best_count;
    logic [SEED_W-1:0] best_seed;
    logic              busy;
    logic              done;
    logic              hit;
    logic              sg_reset;
    logic              sg_enable;
    logic [CW-1:0]     pop_count;

    pattern_tracker #(.LANES(LANES)) u_tracker (
        .clock      (clock),
        .reset      (reset),
        .clear      (state == LOAD),
        .sample     (state == RUN),
        .pattern    (bus.pattern),
`ifdef LFSR_SCAN_HIST_EN
        .hist_addr  (bus.hist_addr),
        .hist_data  (bus.hist_data),
`endif
        .uniq_count (pop_count)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            seed       <= '0;
            run_cnt    <= '0;
            cur_count  <= '0;
            best_count <= '0;
            best_seed  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            hit        <= 1'b0;
            sg_reset   <= 1'b1;
            sg_enable  <= 1'b0;
        end else begin
            done <= 1'b0;
            hit  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state      <= LOAD;
                        seed       <= '0;
                        best_count <= '0;
                        best_seed  <= '0;
                        busy       <= 1'b1;
                        sg_reset   <= 1'b1;
                    end
                end
                LOAD: begin
                    state     <= RUN;
                    run_cnt   <= '0;
                    sg_reset  <= 1'b0;
                    sg_enable <= 1'b1;
                end
                RUN: begin
                    if (run_cnt == RUN_END) begin
                        state     <= COUNT;
                        sg_enable <= 1'b0;
                    end else begin
                        run_cnt <= run_cnt + RC_W'(1);
                    end
                end
                COUNT: begin
                    // hit is judged on the fresh popcount so it lands in EVAL.
                    state     <= EVAL;
                    cur_count <= pop_count;
                    hit       <= (32'(pop_count) >= THR_U);
                end
                EVAL: begin
                    state <= NEXT;
                    if (cur_count > best_count) begin
                        best_count <= cur_count;
                        best_seed  <= seed;
                    end
                    done <= (seed == SEED_END);
                end
                NEXT: begin
                    sg_reset <= 1'b1;
                    if (seed == SEED_END) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= LOAD;
                        seed  <= seed + SEED_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    sg_reset  <= 1'b1;
                    sg_enable <= 1'b0;
                end
            endcase
        end
    end

    // Seed index maps MSB-first onto the five lane seeds.
    assign bus.INIT_0     = seed[SEED_W-1 -: WIDTH];
    assign bus.INIT_1     = seed[2*WIDTH2+2*WIDTH-1 -: WIDTH];
    assign bus.INIT_2     = seed[2*WIDTH2+WIDTH-1 -: WIDTH];
    assign bus.INIT_3     = seed[2*WIDTH2-1 -: WIDTH2];
    assign bus.INIT_4     = seed[WIDTH2-1:0];
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.hit        = hit;
    assign bus.sg_reset   = sg_reset;
    assign bus.sg_enable  = sg_enable;
    assign bus.cur_count  = cur_count;
    assign bus.best_count = best_count;
    assign bus.best_seed  = best_seed;

endmodule

// File: tb/tb_lfsr_seed_scanner.sv
// Directed bench: two scanner instances (8-cycle single seed, 32-cycle three seeds).
// Histogram checks are compiled in with LFSR_SCAN_HIST_EN.
module tb_lfsr_seed_scanner;
    import lfsr_scan_pkg::*;

    localparam int RA     = 8;
    localparam int RB     = 32;
    localparam int BUDGET = 400;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    int base_a    = 3;
    int uniq_a    = 1;
    bit hist_mode = 1'b0;
    int uniq_b [8];

    lfsr_seed_scanner_if #(.WIDTH(4), .WIDTH2(3), .LANES(5)) ba ();
    lfsr_seed_scanner_if #(.WIDTH(4), .WIDTH2(3), .LANES(5)) bb ();

    lfsr_seed_scanner #(.WIDTH(4), .WIDTH2(3), .LANES(5), .RUN_CYCLES(RA),
                        .THRESHOLD(24), .SEED_LAST(0)) dut_a (
        .clock (clock),
        .reset (rst_n),
        .bus   (ba)
    );

    lfsr_seed_scanner #(.WIDTH(4), .WIDTH2(3), .LANES(5), .RUN_CYCLES(RB),
                        .THRESHOLD(24), .SEED_LAST(2)) dut_b (
        .clock (clock),
        .reset (rst_n),
        .bus   (bb)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // sig_gen stand-ins: new pattern each RUN cycle, sampled at the following rising edge.
    initial begin
        int ia;
        ia = 0;
        ba.pattern = '0;
        forever begin
            @(negedge clock);
            if (ba.sg_enable) begin
                if (hist_mode) ba.pattern = (ia < 5) ? 5'd7 : 5'(10 + ia);
                else           ba.pattern = 5'(base_a + ia % uniq_a);
                ia++;
            end else begin
                ia = 0;
            end
        end
    end

    initial begin
        int ib;
        ib = 0;
        bb.pattern = '0;
        forever begin
            @(negedge clock);
            if (bb.sg_enable) begin
                bb.pattern = 5'(ib % uniq_b[int'(bb.INIT_4)]);
                ib++;
            end else begin
                ib = 0;
            end
        end
    end

    // Cycle 0 is the LOAD cycle right after start is taken.
    task automatic sweep(input bit on_b, input int extra_start,
                         output int done_cyc, output int first_hit, output int hits,
                         output int probe0, output int probe2);
        int cyc;
        int r;
        r = on_b ? RB : RA;
        done_cyc = -1; first_hit = -1; hits = 0; probe0 = -1; probe2 = -1;
        @(negedge clock);
        if (on_b) bb.start = 1'b1; else ba.start = 1'b1;
        @(posedge clock); #1;
        ba.start = 1'b0;
        bb.start = 1'b0;
        cyc = 0;
        while (cyc < BUDGET && done_cyc < 0) begin
            if (on_b ? bb.hit : ba.hit) begin
                hits++;
                if (first_hit < 0) first_hit = cyc;
            end
            if (on_b ? bb.done : ba.done) done_cyc = cyc;
            if (cyc == 1)
                probe0 = on_b ? int'({bb.INIT_0, bb.INIT_1, bb.INIT_2, bb.INIT_3, bb.INIT_4})
                              : int'({ba.INIT_0, ba.INIT_1, ba.INIT_2, ba.INIT_3, ba.INIT_4});
            if (on_b && cyc == 2 * (r + 4) + 1)
                probe2 = int'({bb.INIT_0, bb.INIT_1, bb.INIT_2, bb.INIT_3, bb.INIT_4});
            @(posedge clock); #1;
            cyc++;
            if (on_b) bb.start = (cyc == extra_start);
        end
        @(posedge clock); #1;
        bb.start = 1'b0;
    endtask

    initial begin
        int dc, fh, nh, p0, p2;
        ba.start = 1'b0;
        bb.start = 1'b0;
        for (int i = 0; i < 8; i++) uniq_b[i] = 32;
`ifdef LFSR_SCAN_HIST_EN
        ba.hist_addr = '0;
        bb.hist_addr = '0;
`endif
        rst_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_busy",      int'(ba.busy), 0);
        check_eq("rst_sg_reset",  int'(ba.sg_reset), 1);
        check_eq("rst_sg_enable", int'(bb.sg_enable), 0);
        check_eq("rst_done",      int'(ba.done), 0);
        check_eq("rst_hit",       int'(bb.hit), 0);
        check_eq("rst_cur",       int'(bb.cur_count), 0);
        check_eq("rst_best",      int'(bb.best_count), 0);
        check_eq("rst_best_seed", int'(bb.best_seed), 0);
        check_eq("rst_init",      int'({bb.INIT_0, bb.INIT_1, bb.INIT_2, bb.INIT_3, bb.INIT_4}), 0);
        @(negedge clock) rst_n = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check_eq("idle_wait_busy", int'(bb.busy), 0);

        // Constant 5'h03 for 8 samples.
        sweep(1'b0, -1, dc, fh, nh, p0, p2);
        check_eq("s1_done_cyc", dc, RA + 3);
        check_eq("s1_cur",      int'(ba.cur_count), 1);
        check_eq("s1_hits",     nh, 0);
        check_eq("s1_best",     int'(ba.best_count), 1);
        check_eq("s1_busy_end", int'(ba.busy), 0);

        // All 32 patterns each seed.
        sweep(1'b1, -1, dc, fh, nh, p0, p2);
        check_eq("s2_done_cyc",  dc, 3 * (RB + 4) - 1);
        check_eq("s2_first_hit", fh, RB + 2);
        check_eq("s2_hits",      nh, 3);
        check_eq("s2_cur",       int'(bb.cur_count), 32);
        check_eq("s2_best",      int'(bb.best_count), 32);
        check_eq("s2_seed2",     p2, 2);

        // Tie between seeds 0 and 1 keeps seed 0.
        uniq_b[0] = 25; uniq_b[1] = 25; uniq_b[2] = 10;
        sweep(1'b1, -1, dc, fh, nh, p0, p2);
        check_eq("s3_best_seed", int'(bb.best_seed), 0);
        check_eq("s3_best",      int'(bb.best_count), 25);
        check_eq("s3_cur",       int'(bb.cur_count), 10);
        check_eq("s3_hits",      nh, 2);
        check_eq("s3_done_cyc",  dc, 3 * (RB + 4) - 1);

        // Stray start in RUN must not disturb the sweep.
        uniq_b[0] = 10; uniq_b[1] = 30; uniq_b[2] = 20;
        sweep(1'b1, 10, dc, fh, nh, p0, p2);
        check_eq("s5_done_cyc",  dc, 3 * (RB + 4) - 1);
        check_eq("s5_best_seed", int'(bb.best_seed), 1);
        check_eq("s5_best",      int'(bb.best_count), 30);
        check_eq("s5_hits",      nh, 1);

        // Reset in RUN cycle 5.
        @(negedge clock) bb.start = 1'b1;
        @(posedge clock); #1;
        bb.start = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        check_eq("s4_pre_enable", int'(bb.sg_enable), 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("s4_busy",      int'(bb.busy), 0);
        check_eq("s4_sg_reset",  int'(bb.sg_reset), 1);
        check_eq("s4_sg_enable", int'(bb.sg_enable), 0);
        check_eq("s4_cur",       int'(bb.cur_count), 0);
        @(negedge clock) rst_n = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        check_eq("s4_no_restart", int'(bb.busy), 0);
        for (int i = 0; i < 8; i++) uniq_b[i] = 32;
        sweep(1'b1, -1, dc, fh, nh, p0, p2);
        check_eq("s4_seed0",    p0, 0);
        check_eq("s4_done_cyc", dc, 3 * (RB + 4) - 1);
        check_eq("s4_best",     int'(bb.best_count), 32);

`ifdef LFSR_SCAN_HIST_EN
        // 5'h07 for 5 samples, then 15,16,17.
        hist_mode = 1'b1;
        sweep(1'b0, -1, dc, fh, nh, p0, p2);
        ba.hist_addr = 5'd7;
        #1;
        check_eq("h_addr7", int'(ba.hist_data), 5);
        ba.hist_addr = 5'd15;
        #1;
        check_eq("h_addr15", int'(ba.hist_data), 1);
        ba.hist_addr = 5'd3;
        #1;
        check_eq("h_addr3", int'(ba.hist_data), 0);
        check_eq("h_cur", int'(ba.cur_count), 4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
